// File: rtl/rom_pkg.sv
// Shared constants and FSM state encoding for the ROM stream reader.
package rom_pkg;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 4;
  localparam int LEN_W      = 5;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_t;
endpackage

// File: rtl/rom_rd_fifo.sv
// Small synchronous FIFO that buffers captured ROM words ahead of the stream port.
module rom_rd_fifo
  import rom_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [DEPTH-1:0][DW-1:0] mem;
  logic [PW-1:0]            wp, rp;
  logic                     do_push, do_pop;

  // Protect storage against misuse; the reader's issue rule already keeps push off when full.
  assign do_push = push & (count != CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign rdata   = mem[rp];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rom_stream_reader.sv
// Issues wrapping ROM reads for a start/length command and streams the words out valid/ready.
module rom_stream_reader #(
  parameter int ADDR_W = rom_pkg::ADDR_W,
  parameter int DATA_W = rom_pkg::DATA_W,
  parameter int LEN_W  = rom_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);
  import rom_pkg::*;

  localparam int SW = FIFO_CNT_W + 1;

  rd_state_t             state;
  logic [LEN_W-1:0]      len_q, iss_left, beat_cnt;
  logic                  inflight;
  logic [FIFO_CNT_W-1:0] fifo_cnt;
  logic                  fifo_empty, pop, last_hs, room;
  logic [SW-1:0]         outstanding;

  // Words already buffered plus reads still on their way: rom_en marks this cycle's read,
  // inflight the previous one whose data lands now. A pop in this cycle is deliberately ignored.
  assign outstanding = SW'(fifo_cnt) + SW'(inflight) + SW'(rom_en);
  assign room        = (outstanding < SW'(FIFO_DEPTH));

  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;
  assign m_last  = m_valid & (beat_cnt == (len_q - 1'b1));
  assign last_hs = pop & m_last;

  rom_rd_fifo #(.DW(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .wdata (rom_data),
    .pop   (pop),
    .rdata (m_data),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  // Transfer control: command latch, read issue/address generation and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      len_q    <= '0;
      iss_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // FINISH shares IDLE's command acceptance so a start in the done cycle is taken.
        IDLE, FINISH: begin
          rom_en <= 1'b0;
          state  <= IDLE;
          if (start) begin
            len_q <= length;
            if (length == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state    <= FETCH;
              busy     <= 1'b1;
              rom_en   <= 1'b1;
              rom_addr <= start_addr;
              iss_left <= length - 1'b1;
            end
          end
        end
        FETCH: begin
          if (iss_left == '0) begin
            rom_en <= 1'b0;
            state  <= DRAIN;
          end else if (room) begin
            rom_en   <= 1'b1;
            rom_addr <= rom_addr + 1'b1;
            iss_left <= iss_left - 1'b1;
          end else begin
            rom_en <= 1'b0;
          end
        end
        DRAIN: begin
          rom_en <= 1'b0;
          if (last_hs) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One read in flight per issued cycle; its data is captured the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= rom_en;
  end

  // Count accepted beats to locate the final word of the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   beat_cnt <= '0;
    else if (start && (state == IDLE || state == FINISH)) beat_cnt <= '0;
    else if (pop)                                 beat_cnt <= beat_cnt + 1'b1;
  end
endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench: a ROM responder model, expected beat/address queues filled at start,
// and a monitor that checks every ROM read and every stream handshake.
module tb_rom_stream_reader;
  logic       clk = 1'b0;
  logic       rst_n, start, busy, done, rom_en, m_valid, m_last, m_ready;
  logic [3:0] start_addr, rom_addr, rom_data, m_data;
  logic [4:0] length;

  int total = 0, bad = 0;
  int cyc = 0, t_start = 0, first_v = -1, first_en = -1;
  int iss_cnt = 0, hs_cnt = 0, max_out = 0;
  bit bp_mode = 0;
  logic [4:0] exp_beat[$];
  logic [3:0] exp_addr[$];
  logic [3:0] rom_tbl[16];

  rom_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // ROM contents: 2,2,E,2,4,A,C,0 at 0-7, repeated at 8-15.
  initial begin
    rom_tbl = '{4'h2, 4'h2, 4'hE, 4'h2, 4'h4, 4'hA, 4'hC, 4'h0,
                4'h2, 4'h2, 4'hE, 4'h2, 4'h4, 4'hA, 4'hC, 4'h0};
  end

  // Synchronous ROM responder, X while disabled.
  always @(posedge clk) rom_data <= rom_en ? rom_tbl[rom_addr] : 4'bx;

  // Downstream ready: held high, or toggling every cycle in backpressure mode.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = bp_mode ? ~m_ready : 1'b1;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: checks ROM addresses, stream beats, hold-under-stall, outstanding reads.
  initial begin
    bit stall_q = 0;
    logic [3:0] pd;
    logic pl;
    logic [4:0] eb;
    logic [3:0] ea;
    int o;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        o = iss_cnt + int'(rom_en) - hs_cnt;
        if (o > max_out) max_out = o;
        if (rom_en) begin
          if (first_en < 0) first_en = cyc;
          if (exp_addr.size() == 0) check("rom_en_unexpected", 1, 0);
          else begin
            ea = exp_addr.pop_front();
            check("rom_addr", rom_addr, ea);
          end
          iss_cnt++;
        end
        if (m_valid && first_v < 0) first_v = cyc;
        if (stall_q) begin
          check("stall_valid_held", m_valid, 1);
          check("stall_data_held", m_data, pd);
          check("stall_last_held", m_last, pl);
        end
        if (m_valid && m_ready) begin
          if (exp_beat.size() == 0) check("beat_unexpected", 1, 0);
          else begin
            eb = exp_beat.pop_front();
            check("m_data", m_data, eb[3:0]);
            check("m_last", m_last, eb[4]);
          end
          hs_cnt++;
        end
        stall_q = m_valid && !m_ready;
        pd = m_data;
        pl = m_last;
      end else stall_q = 0;
    end
  end

  // Present a command for one sampling edge and queue the expected reads/beats.
  task automatic issue(input logic [3:0] a, input logic [4:0] n);
    logic [3:0] ad;
    start = 1'b1; start_addr = a; length = n;
    t_start = cyc; first_v = -1; first_en = -1;
    iss_cnt = 0; hs_cnt = 0; max_out = 0;
    for (int k = 0; k < int'(n); k++) begin
      ad = a + 4'(k);
      exp_addr.push_back(ad);
      exp_beat.push_back({(k == int'(n) - 1), rom_tbl[ad]});
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, int'(n != 0));
  endtask

  // Wait (bounded) for done; returns at the negedge of the done cycle.
  task automatic wait_done(input int exp_cyc, input string nm);
    bit seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check({nm, "_done_seen"}, seen, 1);
    if (seen) begin
      if (exp_cyc >= 0) check({nm, "_done_cycle"}, cyc - t_start, exp_cyc - t_start);
      check({nm, "_busy_in_done"}, busy, 0);
      check({nm, "_beats_left"}, exp_beat.size(), 0);
    end
  endtask

  task automatic done_one_cycle(input string nm);
    @(negedge clk);
    check({nm, "_done_pulse_len"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", busy, 0);     check("rst_done", done, 0);
    check("rst_rom_en", rom_en, 0); check("rst_rom_addr", rom_addr, 0);
    check("rst_m_valid", m_valid, 0); check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    rst_n = 1'b1;

    // Basic transfer: 2,2,E,2 contiguous.
    @(posedge clk); #1;
    issue(4'd0, 5'd4);
    wait_done(t_start + 7, "basic");
    check("basic_first_rom_en", first_en - t_start, 1);
    check("basic_first_valid", first_v - t_start, 3);
    check("basic_beats", hs_cnt, 4);
    done_one_cycle("basic");

    // Empty transfer, then a start in its done cycle: wrap 14,15,0,1 -> C,0,2,2.
    @(posedge clk); #1;
    issue(4'd3, 5'd0);
    wait_done(t_start + 1, "empty");
    check("empty_rom_en_count", iss_cnt, 0);
    issue(4'd14, 5'd4);
    wait_done(t_start + 7, "wrap");
    check("wrap_first_rom_en", first_en - t_start, 1);
    check("wrap_beats", hs_cnt, 4);
    done_one_cycle("wrap");

    // Backpressure with alternating ready.
    bp_mode = 1;
    @(posedge clk); #1;
    issue(4'd0, 5'd8);
    wait_done(-1, "bp");
    check("bp_beats", hs_cnt, 8);
    check("bp_outstanding_le4", int'(max_out <= 4), 1);
    bp_mode = 0;
    @(posedge clk); @(posedge clk); #1;

    // Length 17: revisits address 0 on the last beat.
    issue(4'd0, 5'd17);
    wait_done(t_start + 20, "len17");
    check("len17_beats", hs_cnt, 17);
    check("len17_max_outstanding", max_out, 3);

    // Start while busy is ignored.
    @(posedge clk); #1;
    issue(4'd0, 5'd4);
    start = 1'b1; start_addr = 4'd9; length = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(t_start + 7, "ignored");
    check("ignored_beats", hs_cnt, 4);
    done_one_cycle("ignored");

    // Reset after the third beat, then a fresh transfer from address 5.
    @(posedge clk); #1;
    issue(4'd0, 5'd8);
    for (int k = 0; k < 50 && hs_cnt < 3; k++) @(negedge clk);
    check("mid_three_beats", hs_cnt, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);     check("mid_rst_rom_en", rom_en, 0);
    check("mid_rst_m_valid", m_valid, 0); check("mid_rst_m_last", m_last, 0);
    check("mid_rst_rom_addr", rom_addr, 0); check("mid_rst_m_data", m_data, 0);
    check("mid_rst_done", done, 0);
    exp_beat.delete();
    exp_addr.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'd5, 5'd2);
    wait_done(t_start + 5, "post_rst");
    check("post_rst_beats", hs_cnt, 2);

    @(posedge clk); @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
